fast_countdown: RTL and testbench
=================================

FAST_COUNTDOWN -- requirements
Module: fast_countdown

Interface
REQ-001 Parameter DW, default 32: half-width; the counter is 2*DW bits wide; DW SHALL be even and at least 8.
REQ-002 Parameter AUTO_RELOAD, default 1: 1 selects periodic mode, 0 selects one-shot mode.
REQ-003 s_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 s_resetn_i  input  1  reset, synchronous and active-low.
REQ-005 s_wen_i  input  1  write strobe, one write per cycle.
REQ-006 s_wsel_i  input  2  write target: 0 count low half, 1 count high half, 2 reload low half, 3 reload high half.
REQ-007 s_wdata_i  input  DW  write data.
REQ-008 s_start_i  input  1  start pulse: IDLE/DONE to RUN.
REQ-009 s_stop_i  input  1  stop pulse: RUN to IDLE.
REQ-010 s_en_i  input  1  count enable (tick), sampled only in RUN.
REQ-011 s_cnt_o  output  2*DW  current count {high, low}, taken directly from registers.
REQ-012 s_valid_o  output  1  s_cnt_o is coherent (no borrow pending).
REQ-013 s_expire_o  output  1  one-cycle expiry pulse.
REQ-014 s_run_o  output  1  state == RUN.

Function
REQ-015 States SHALL be IDLE, RUN and DONE; the count SHALL change only by a write, a decrement or a reload.
REQ-016 IDLE->RUN and DONE->RUN on s_start_i; RUN->IDLE on s_stop_i; s_stop_i SHALL win over s_start_i.
REQ-017 In RUN with s_en_i=1, the low half SHALL decrement by 1 each cycle using a DW-bit subtract only; no 2*DW-bit carry chain is allowed.
REQ-018 A low-half wrap from 0 to all-ones SHALL set a registered borrow flag; the next cycle the high half SHALL decrement by 1 and the flag SHALL clear, regardless of s_en_i.
REQ-019 s_valid_o SHALL be 0 exactly while the borrow flag is set.
REQ-020 Expiry SHALL occur when the state is RUN, s_en_i=1, no borrow is pending and the count is 0.
REQ-021 On expiry, s_expire_o SHALL pulse for 1 cycle. If AUTO_RELOAD=1, the count SHALL load the full reload value and the state SHALL stay RUN. If AUTO_RELOAD=0, the count SHALL hold 0 and the state SHALL go to DONE.
REQ-022 A reload value of 0 in periodic mode SHALL expire on every enabled cycle.
REQ-023 A write SHALL take effect next cycle, in any state.
REQ-024 A count write SHALL take priority over a same-cycle decrement, borrow or reload on both halves.
REQ-025 A count write SHALL clear any pending borrow.
REQ-026 The unwritten count half SHALL hold; a pending borrow SHALL NOT be applied to it.
REQ-027 A reload write concurrent with expiry: the reload SHALL use the pre-write reload value.
REQ-028 A count write concurrent with expiry SHALL suppress s_expire_o.
REQ-029 Counts in IDLE/DONE SHALL hold, and s_en_i SHALL be ignored there.

Reset
REQ-030 While s_resetn_i=0 at a clock edge, on that edge the block SHALL set: state IDLE, count 0, reload 0, borrow flag 0, s_expire_o 0, s_valid_o 1, s_run_o 0.
REQ-031 Reset asserted mid-operation SHALL abandon any pending borrow or expiry; no s_expire_o pulse SHALL follow it.

Structure
REQ-032 The state enum and the s_wsel_i codes (CNT_LO, CNT_HI, RLD_LO, RLD_HI) SHALL be defined in p_hardisc.
REQ-033 One sub-module, cd_half, SHALL hold one DW-bit register with load, decrement and wrap-out, instantiated twice.
REQ-034 All outputs SHALL be registered or direct register copies.

Verification (DW=32)
REQ-035 Periodic mode: reload=3, start, s_en_i=1 constantly -> count 3,2,1,0, then s_expire_o on the cycle after count 0 is reached, reload to 3, period 4 cycles.
REQ-036 Borrow: count=0x1_00000000, one tick -> low=0xFFFFFFFF, high=1 with s_valid_o=0 for 1 cycle -> then 0x0_FFFFFFFF with s_valid_o=1.
REQ-037 One-shot (AUTO_RELOAD=0): count=2, ticks -> s_expire_o once, state DONE, count holds 0, further ticks give no pulse; s_start_i then re-enters RUN, next tick expires again.
REQ-038 Collision: write CNT_LO=5 on the borrow cycle after a 0x2_00000000 tick -> count=0x2_00000005, borrow dropped.
REQ-039 Reset with a borrow pending (count 0x1_00000000 ticked) -> next cycle count 0, IDLE, s_valid_o=1, no s_expire_o.
REQ-040 Reload=0, periodic, s_en_i toggling 1,0,1 -> s_expire_o pulses exactly on the enabled cycles.

Source files
------------

// File: rtl/fast_countdown_pkg.sv
// Shared state and write-select encodings for the split-half countdown timer.
package p_hardisc;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cd_state_e;

    typedef enum logic [1:0] {
        CNT_LO = 2'd0,
        CNT_HI = 2'd1,
        RLD_LO = 2'd2,
        RLD_HI = 2'd3
    } cd_wsel_e;

endpackage

// File: rtl/fast_countdown_cd_half.sv
// One DW-bit half of the countdown register: load has priority over decrement,
// wrap flags a decrement out of zero so the caller can borrow from the next half.
module cd_half #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic [DW-1:0] q,
    output logic          wrap
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= q - ONE;
        end
    end

    assign wrap = dec && !load && (q == '0);

endmodule

// File: rtl/fast_countdown.sv
// 2*DW-bit countdown timer built from two DW-bit halves; a low-half wrap is
// carried into the high half one cycle later through a registered borrow flag.
module fast_countdown
    import p_hardisc::*;
#(
    parameter int unsigned DW          = 32,
    parameter bit          AUTO_RELOAD = 1'b1
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          s_wen_i,
    input  logic [1:0]    s_wsel_i,
    input  logic [DW-1:0] s_wdata_i,
    input  logic          s_start_i,
    input  logic          s_stop_i,
    input  logic          s_en_i,
    output logic [2*DW-1:0] s_cnt_o,
    output logic          s_valid_o,
    output logic          s_expire_o,
    output logic          s_run_o
);

    if ((DW < 8) || ((DW % 2) != 0)) begin : g_bad_dw
        $error("fast_countdown: DW must be even and at least 8");
    end

    cd_state_e     state, state_next;
    logic [DW-1:0] lo_q, hi_q, rld_lo, rld_hi;
    logic [DW-1:0] lo_val, hi_val;
    logic          borrow, borrow_next;
    logic          expire_r, valid_r, run_r;
    logic          wr_cnt_lo, wr_cnt_hi, wr_cnt, wr_rld_lo, wr_rld_hi;
    logic          tick, cnt_zero, expire_now, expire_eff, reload;
    logic          lo_load, hi_load, lo_dec, hi_dec, lo_wrap, hi_wrap;

    cd_half #(.DW(DW)) u_lo (
        .clk      (s_clk_i),
        .resetn   (s_resetn_i),
        .load     (lo_load),
        .load_val (lo_val),
        .dec      (lo_dec),
        .q        (lo_q),
        .wrap     (lo_wrap)
    );

    cd_half #(.DW(DW)) u_hi (
        .clk      (s_clk_i),
        .resetn   (s_resetn_i),
        .load     (hi_load),
        .load_val (hi_val),
        .dec      (hi_dec),
        .q        (hi_q),
        .wrap     (hi_wrap)
    );

    always_comb begin
        wr_cnt_lo  = 1'b0;
        wr_cnt_hi  = 1'b0;
        wr_rld_lo  = 1'b0;
        wr_rld_hi  = 1'b0;
        if (s_wen_i) begin
            unique case (cd_wsel_e'(s_wsel_i))
                CNT_LO: wr_cnt_lo = 1'b1;
                CNT_HI: wr_cnt_hi = 1'b1;
                RLD_LO: wr_rld_lo = 1'b1;
                RLD_HI: wr_rld_hi = 1'b1;
            endcase
        end
        wr_cnt     = wr_cnt_lo || wr_cnt_hi;

        tick       = (state == RUN) && s_en_i;
        cnt_zero   = (lo_q == '0) && (hi_q == '0);
        expire_now = tick && !borrow && cnt_zero;
        // A count write cancels the whole expiry: no pulse, no reload, no DONE.
        expire_eff = expire_now && !wr_cnt;
        reload     = expire_eff && AUTO_RELOAD;

        lo_load    = wr_cnt_lo || (!wr_cnt && reload);
        hi_load    = wr_cnt_hi || (!wr_cnt && reload);
        lo_val     = wr_cnt_lo ? s_wdata_i : rld_lo;
        hi_val     = wr_cnt_hi ? s_wdata_i : rld_hi;
        lo_dec     = tick && !wr_cnt && !expire_now;
        hi_dec     = borrow && !wr_cnt;
        borrow_next = lo_wrap;

        state_next = state;
        unique case (state)
            IDLE, DONE: if (s_start_i && !s_stop_i) state_next = RUN;
            RUN: begin
                if (s_stop_i)                        state_next = IDLE;
                else if (expire_eff && !AUTO_RELOAD) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state    <= IDLE;
            borrow   <= 1'b0;
            rld_lo   <= '0;
            rld_hi   <= '0;
            expire_r <= 1'b0;
            valid_r  <= 1'b1;
            run_r    <= 1'b0;
        end else begin
            // The high half only ever absorbs a borrow while it is non-zero.
            assert (!hi_wrap);
            state    <= state_next;
            borrow   <= borrow_next;
            if (wr_rld_lo) rld_lo <= s_wdata_i;
            if (wr_rld_hi) rld_hi <= s_wdata_i;
            expire_r <= expire_eff;
            valid_r  <= !borrow_next;
            run_r    <= (state_next == RUN);
        end
    end

    assign s_cnt_o    = {hi_q, lo_q};
    assign s_valid_o  = valid_r;
    assign s_expire_o = expire_r;
    assign s_run_o    = run_r;

endmodule

// File: tb/tb_fast_countdown.sv
// Table-driven bench for fast_countdown (DW=32): periodic and one-shot instances
// share stimulus; each vector's expected outputs are queued and checked after the edge.
module tb_fast_countdown;

    typedef struct {
        string       name;
        bit          sel;      // 0: periodic instance, 1: one-shot instance
        logic        rstn;
        logic        wen;
        logic [1:0]  wsel;
        logic [31:0] wd;
        logic        start;
        logic        stop;
        logic        en;
        logic [63:0] cnt;
        logic        valid;
        logic        expire;
        logic        run;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn, wen, start, stop, en;
    logic [1:0]  wsel;
    logic [31:0] wdata;
    logic [63:0] cnt_p, cnt_o;
    logic        valid_p, valid_o, expire_p, expire_o, run_p, run_o;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    vec_t        vecs[$];
    vec_t        sb[$];

    always #5 clk = ~clk;

    fast_countdown #(.DW(32), .AUTO_RELOAD(1'b1)) u_per (
        .s_clk_i    (clk),
        .s_resetn_i (resetn),
        .s_wen_i    (wen),
        .s_wsel_i   (wsel),
        .s_wdata_i  (wdata),
        .s_start_i  (start),
        .s_stop_i   (stop),
        .s_en_i     (en),
        .s_cnt_o    (cnt_p),
        .s_valid_o  (valid_p),
        .s_expire_o (expire_p),
        .s_run_o    (run_p)
    );

    fast_countdown #(.DW(32), .AUTO_RELOAD(1'b0)) u_one (
        .s_clk_i    (clk),
        .s_resetn_i (resetn),
        .s_wen_i    (wen),
        .s_wsel_i   (wsel),
        .s_wdata_i  (wdata),
        .s_start_i  (start),
        .s_stop_i   (stop),
        .s_en_i     (en),
        .s_cnt_o    (cnt_o),
        .s_valid_o  (valid_o),
        .s_expire_o (expire_o),
        .s_run_o    (run_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic add(input string nm, input bit sel, input logic rstn, input logic w,
                       input logic [1:0] ws, input logic [31:0] wd, input logic st,
                       input logic sp, input logic e, input logic [63:0] c,
                       input logic v, input logic x, input logic r);
        vec_t t;
        t.name = nm; t.sel = sel; t.rstn = rstn; t.wen = w; t.wsel = ws; t.wd = wd;
        t.start = st; t.stop = sp; t.en = e; t.cnt = c; t.valid = v; t.expire = x; t.run = r;
        vecs.push_back(t);
    endtask

    // Checker: pops the expectation for the edge that just happened.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    chk({e.name, ".cnt"},    cnt_o,    e.cnt);
                    chk({e.name, ".valid"},  64'(valid_o),  64'(e.valid));
                    chk({e.name, ".expire"}, 64'(expire_o), 64'(e.expire));
                    chk({e.name, ".run"},    64'(run_o),    64'(e.run));
                end else begin
                    chk({e.name, ".cnt"},    cnt_p,    e.cnt);
                    chk({e.name, ".valid"},  64'(valid_p),  64'(e.valid));
                    chk({e.name, ".expire"}, 64'(expire_p), 64'(e.expire));
                    chk({e.name, ".run"},    64'(run_p),    64'(e.run));
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; wen = 1'b0; wsel = 2'd0; wdata = '0;
        start = 1'b0; stop = 1'b0; en = 1'b0;

        //   name            sel rn wen ws wd    st sp en cnt                 v x r
        // periodic: reload 3, period 4, reload write during expiry uses old value
        add("per_rst",        0, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("per_wr_rld",     0, 1, 1, 2, 3,    0, 0, 0, 64'h0,              1, 0, 0);
        add("per_start",      0, 1, 0, 0, 0,    1, 0, 0, 64'h0,              1, 0, 1);
        add("per_exp0",       0, 1, 0, 0, 0,    0, 0, 1, 64'h3,              1, 1, 1);
        add("per_t2",         0, 1, 0, 0, 0,    0, 0, 1, 64'h2,              1, 0, 1);
        add("per_t1",         0, 1, 0, 0, 0,    0, 0, 1, 64'h1,              1, 0, 1);
        add("per_t0",         0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 1);
        add("per_exp1_rldwr", 0, 1, 1, 2, 7,    0, 0, 1, 64'h3,              1, 1, 1);
        add("per_t2b",        0, 1, 0, 0, 0,    0, 0, 1, 64'h2,              1, 0, 1);
        add("per_noen",       0, 1, 0, 0, 0,    0, 0, 0, 64'h2,              1, 0, 1);
        add("per_t1b",        0, 1, 0, 0, 0,    0, 0, 1, 64'h1,              1, 0, 1);
        add("per_t0b",        0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 1);
        add("per_exp_newrld", 0, 1, 0, 0, 0,    0, 0, 1, 64'h7,              1, 1, 1);
        add("per_stop",       0, 1, 0, 0, 0,    0, 1, 0, 64'h7,              1, 0, 0);
        add("per_idle_en",    0, 1, 0, 0, 0,    0, 0, 1, 64'h7,              1, 0, 0);
        add("per_start_stop", 0, 1, 0, 0, 0,    1, 1, 0, 64'h7,              1, 0, 0);
        add("per_restart",    0, 1, 0, 0, 0,    1, 0, 0, 64'h7,              1, 0, 1);
        add("per_t6",         0, 1, 0, 0, 0,    0, 0, 1, 64'h6,              1, 0, 1);
        // borrow from low into high half, one cycle of incoherence
        add("bor_rst",        0, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("bor_wr_hi",      0, 1, 1, 1, 1,    0, 0, 0, 64'h1_0000_0000,    1, 0, 0);
        add("bor_start",      0, 1, 0, 0, 0,    1, 0, 0, 64'h1_0000_0000,    1, 0, 1);
        add("bor_tick",       0, 1, 0, 0, 0,    0, 0, 1, 64'h1_FFFF_FFFF,    0, 0, 1);
        add("bor_apply",      0, 1, 0, 0, 0,    0, 0, 0, 64'h0_FFFF_FFFF,    1, 0, 1);
        add("bor_hold",       0, 1, 0, 0, 0,    0, 0, 0, 64'h0_FFFF_FFFF,    1, 0, 1);
        add("bor_tick2",      0, 1, 0, 0, 0,    0, 0, 1, 64'h0_FFFF_FFFE,    1, 0, 1);
        // count write on the borrow cycle drops the borrow
        add("col_rst",        0, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("col_wr_hi",      0, 1, 1, 1, 2,    0, 0, 0, 64'h2_0000_0000,    1, 0, 0);
        add("col_start",      0, 1, 0, 0, 0,    1, 0, 0, 64'h2_0000_0000,    1, 0, 1);
        add("col_tick",       0, 1, 0, 0, 0,    0, 0, 1, 64'h2_FFFF_FFFF,    0, 0, 1);
        add("col_wr_lo",      0, 1, 1, 0, 5,    0, 0, 0, 64'h2_0000_0005,    1, 0, 1);
        add("col_hold",       0, 1, 0, 0, 0,    0, 0, 0, 64'h2_0000_0005,    1, 0, 1);
        // count write during expiry suppresses the pulse and the reload
        add("wex_rst",        0, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("wex_wr_rld",     0, 1, 1, 2, 4,    0, 0, 0, 64'h0,              1, 0, 0);
        add("wex_start",      0, 1, 0, 0, 0,    1, 0, 0, 64'h0,              1, 0, 1);
        add("wex_collide",    0, 1, 1, 0, 9,    0, 0, 1, 64'h9,              1, 0, 1);
        add("wex_t8",         0, 1, 0, 0, 0,    0, 0, 1, 64'h8,              1, 0, 1);
        // reload 0: pulse on every enabled cycle; reset kills a pending expiry
        add("z_rst",          0, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("z_start",        0, 1, 0, 0, 0,    1, 0, 0, 64'h0,              1, 0, 1);
        add("z_en1",          0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 1, 1);
        add("z_en0",          0, 1, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 1);
        add("z_en1b",         0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 1, 1);
        add("z_en1c",         0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 1, 1);
        add("z_en0b",         0, 1, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 1);
        add("z_rst_mid",      0, 0, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 0);
        add("z_after_rst",    0, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 0);
        // one-shot instance
        add("one_rst",        1, 0, 0, 0, 0,    0, 0, 0, 64'h0,              1, 0, 0);
        add("one_wr_rld",     1, 1, 1, 2, 5,    0, 0, 0, 64'h0,              1, 0, 0);
        add("one_wr_cnt",     1, 1, 1, 0, 2,    0, 0, 0, 64'h2,              1, 0, 0);
        add("one_start",      1, 1, 0, 0, 0,    1, 0, 0, 64'h2,              1, 0, 1);
        add("one_t1",         1, 1, 0, 0, 0,    0, 0, 1, 64'h1,              1, 0, 1);
        add("one_t0",         1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 1);
        add("one_expire",     1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 1, 0);
        add("one_done_en",    1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 0);
        add("one_done_en2",   1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 0);
        add("one_restart",    1, 1, 0, 0, 0,    1, 0, 0, 64'h0,              1, 0, 1);
        add("one_expire2",    1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 1, 0);
        add("one_after",      1, 1, 0, 0, 0,    0, 0, 1, 64'h0,              1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            resetn = vecs[i].rstn; wen = vecs[i].wen; wsel = vecs[i].wsel; wdata = vecs[i].wd;
            start = vecs[i].start; stop = vecs[i].stop; en = vecs[i].en;
            sb.push_back(vecs[i]);
        end

        // Hand-written corner: reset while a borrow is pending.
        @(negedge clk);
        resetn = 1'b0; wen = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
        @(negedge clk);
        resetn = 1'b1; wen = 1'b1; wsel = 2'd1; wdata = 32'd1;
        @(negedge clk);
        wen = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        chk("rstbor.cnt_pending", cnt_p, 64'h1_FFFF_FFFF);
        chk("rstbor.valid_pending", 64'(valid_p), 64'h0);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("rstbor.cnt", cnt_p, 64'h0);
        chk("rstbor.valid", 64'(valid_p), 64'h1);
        chk("rstbor.run", 64'(run_p), 64'h0);
        chk("rstbor.expire", 64'(expire_p), 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rstbor.cnt_after", cnt_p, 64'h0);
        chk("rstbor.expire_after", 64'(expire_p), 64'h0);

        repeat (2) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
